// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and default parameters for the BIST response analyzer
// Purpose: FSM state encoding and default widths used by bist_response_analyzer.
package bist_pkg;

  localparam int DEF_DW = 8;  // compared RAM word width
  localparam int DEF_AW = 6;  // RAM address tag width
  localparam int DEF_CW = 8;  // fail counter width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_t;

endpackage

// File: rtl/bist_mask_compare.sv
// rtl/bist_mask_compare.sv - masked unsigned magnitude compare of golden vs RAM data
// Purpose: purely combinational; compares (data_t & mask) with (ramout & mask).
// Ports:
//   i_data_t  [DW] golden data
//   i_ramout  [DW] data read from RAM under test
//   i_mask    [DW] per-bit compare enable (1 = compared)
//   o_gt/o_eq/o_lt  masked golden >, ==, < masked RAM data (exactly one high)
//   o_diff    [DW] (data_t ^ ramout) & mask, the failing bit positions
module bist_mask_compare #(
  parameter int DW = bist_pkg::DEF_DW
) (
  input  logic [DW-1:0] i_data_t,
  input  logic [DW-1:0] i_ramout,
  input  logic [DW-1:0] i_mask,
  output logic          o_gt,
  output logic          o_eq,
  output logic          o_lt,
  output logic [DW-1:0] o_diff
);

  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;

  assign w_a    = i_data_t & i_mask;
  assign w_b    = i_ramout & i_mask;
  assign o_gt   = (w_a > w_b);
  assign o_eq   = (w_a == w_b);
  assign o_lt   = (w_a < w_b);
  assign o_diff = (i_data_t ^ i_ramout) & i_mask;

endmodule

// File: rtl/bist_response_analyzer.sv
// rtl/bist_response_analyzer.sv - BIST session FSM, registered compare result and fail statistics
// Purpose: accepts masked compares during a session, reports each result one
// cycle later and accumulates sticky fail, saturating fail count and the
// address/bits of the first mismatch.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_start                  open a new session (IDLE/DONE only), clears stats
//   i_cmp_valid              compare inputs valid this cycle
//   i_data_t/i_ramout/i_mask golden data, RAM data, compare mask [DW]
//   i_addr [AW]              address tag of compared word
//   i_last                   final compare of the session
//   o_res_valid, o_gt/eq/lt  registered compare result (held when not valid)
//   o_fail, o_fail_cnt [CW]  sticky fail flag, saturating mismatch count
//   o_first_fail_addr/bits   address and failing bits of first mismatch
//   o_busy, o_done           FSM in RUN / in DONE
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int CW = DEF_CW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_cmp_valid,
  input  logic [DW-1:0] i_data_t,
  input  logic [DW-1:0] i_ramout,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_mask,
  input  logic          i_last,
  output logic          o_res_valid,
  output logic          o_gt,
  output logic          o_eq,
  output logic          o_lt,
  output logic          o_fail,
  output logic [CW-1:0] o_fail_cnt,
  output logic [AW-1:0] o_first_fail_addr,
  output logic [DW-1:0] o_first_fail_bits,
  output logic          o_busy,
  output logic          o_done
);

  bist_state_t   r_state;
  bist_state_t   w_state_next;
  logic          w_accept;
  logic          w_enter_run;
  logic          w_gt;
  logic          w_eq;
  logic          w_lt;
  logic [DW-1:0] w_diff;

  logic          r_res_valid;
  logic          r_gt;
  logic          r_eq;
  logic          r_lt;
  logic          r_fail;
  logic [CW-1:0] r_fail_cnt;
  logic [AW-1:0] r_first_fail_addr;
  logic [DW-1:0] r_first_fail_bits;

  bist_mask_compare #(.DW(DW)) u_cmp (
    .i_data_t (i_data_t),
    .i_ramout (i_ramout),
    .i_mask   (i_mask),
    .o_gt     (w_gt),
    .o_eq     (w_eq),
    .o_lt     (w_lt),
    .o_diff   (w_diff)
  );

  // Compares only count inside RUN; a start in IDLE/DONE wins over a
  // simultaneous compare because the state is not yet RUN.
  assign w_accept    = (r_state == ST_RUN) && i_cmp_valid;
  assign w_enter_run = (r_state != ST_RUN) && i_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        o_busy = 1'b1;
        if (i_cmp_valid && i_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        if (i_start) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_res_valid <= 1'b0;
      r_gt        <= 1'b0;
      r_eq        <= 1'b0;
      r_lt        <= 1'b0;
    end else begin
      r_res_valid <= w_accept;
      if (w_accept) begin
        r_gt <= w_gt;
        r_eq <= w_eq;
        r_lt <= w_lt;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_enter_run) begin
      r_fail            <= 1'b0;
      r_fail_cnt        <= '0;
      r_first_fail_addr <= '0;
      r_first_fail_bits <= '0;
    end else if (w_accept && !w_eq) begin
      r_fail <= 1'b1;
      if (r_fail_cnt != {CW{1'b1}}) r_fail_cnt <= r_fail_cnt + CW'(1);
      // Only the first mismatch of the session is captured.
      if (!r_fail) begin
        r_first_fail_addr <= i_addr;
        r_first_fail_bits <= w_diff;
      end
    end
  end

  assign o_res_valid       = r_res_valid;
  assign o_gt              = r_gt;
  assign o_eq              = r_eq;
  assign o_lt              = r_lt;
  assign o_fail            = r_fail;
  assign o_fail_cnt        = r_fail_cnt;
  assign o_first_fail_addr = r_first_fail_addr;
  assign o_first_fail_bits = r_first_fail_bits;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb/tb_bist_response_analyzer.sv - directed self-checking bench for bist_response_analyzer
module tb_bist_response_analyzer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       cmp_valid = 1'b0;
  logic [7:0] data_t = '0;
  logic [7:0] ramout = '0;
  logic [5:0] addr = '0;
  logic [7:0] mask = '0;
  logic       last = 1'b0;

  logic       res_valid, gt, eq, lt, fail, busy, done;
  logic [7:0] fail_cnt;
  logic [5:0] ffa;
  logic [7:0] ffb;

  logic       res_valid2, gt2, eq2, lt2, fail2, busy2, done2;
  logic [1:0] fail_cnt2;
  logic [5:0] ffa2;
  logic [7:0] ffb2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bist_response_analyzer #(.DW(8), .AW(6), .CW(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cmp_valid(cmp_valid),
    .i_data_t(data_t), .i_ramout(ramout), .i_addr(addr), .i_mask(mask),
    .i_last(last), .o_res_valid(res_valid), .o_gt(gt), .o_eq(eq), .o_lt(lt),
    .o_fail(fail), .o_fail_cnt(fail_cnt), .o_first_fail_addr(ffa),
    .o_first_fail_bits(ffb), .o_busy(busy), .o_done(done)
  );

  bist_response_analyzer #(.DW(8), .AW(6), .CW(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cmp_valid(cmp_valid),
    .i_data_t(data_t), .i_ramout(ramout), .i_addr(addr), .i_mask(mask),
    .i_last(last), .o_res_valid(res_valid2), .o_gt(gt2), .o_eq(eq2), .o_lt(lt2),
    .o_fail(fail2), .o_fail_cnt(fail_cnt2), .o_first_fail_addr(ffa2),
    .o_first_fail_bits(ffb2), .o_busy(busy2), .o_done(done2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; cmp_valid = 1'b0; last = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drive_cmp(input logic [7:0] d, input logic [7:0] r,
                           input logic [7:0] m, input logic [5:0] a, input logic l);
    cmp_valid = 1'b1; data_t = d; ramout = r; mask = m; addr = a; last = l;
  endtask

  task automatic test_reset();
    start = 1'b1; cmp_valid = 1'b1; data_t = 8'hAA; ramout = 8'h55; mask = 8'hFF;
    rst = 1'b1;
    step();
    rst = 1'b0; idle_inputs();
    n_tests++;
    if ({res_valid, gt, eq, lt, fail, busy, done} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=%b", {res_valid, gt, eq, lt, fail, busy, done}, 7'b0);
    end
    n_tests++;
    if ({fail_cnt, ffa, ffb} !== 22'h0) begin
      n_fail++; $display("FAIL reset_stats got=%h exp=%h", {fail_cnt, ffa, ffb}, 22'h0);
    end
  endtask

  task automatic test_first_fail();
    do_reset();
    do_start();
    n_tests++;
    if ({busy, done} !== 2'b10) begin
      n_fail++; $display("FAIL start_busy got=%b exp=10", {busy, done});
    end
    drive_cmp(8'h10, 8'h00, 8'hFF, 6'd5, 1'b0);
    step();
    idle_inputs();
    n_tests++;
    if ({res_valid, gt, eq, lt, fail} !== 5'b11001) begin
      n_fail++; $display("FAIL ff_result got=%b exp=11001", {res_valid, gt, eq, lt, fail});
    end
    n_tests++;
    if ({fail_cnt, ffa, ffb} !== {8'd1, 6'd5, 8'h10}) begin
      n_fail++; $display("FAIL ff_stats got=%h exp=%h", {fail_cnt, ffa, ffb}, {8'd1, 6'd5, 8'h10});
    end
    step();
    n_tests++;
    if ({res_valid, gt, eq, lt} !== 4'b0100) begin
      n_fail++; $display("FAIL ff_hold got=%b exp=0100", {res_valid, gt, eq, lt});
    end
  endtask

  task automatic test_lt_eq_done();
    do_reset();
    do_start();
    drive_cmp(8'h20, 8'h30, 8'hFF, 6'd3, 1'b0);
    step();
    n_tests++;
    if ({res_valid, gt, eq, lt} !== 4'b1001) begin
      n_fail++; $display("FAIL seq_lt got=%b exp=1001", {res_valid, gt, eq, lt});
    end
    drive_cmp(8'h50, 8'h50, 8'hFF, 6'd4, 1'b1);
    step();
    idle_inputs();
    n_tests++;
    if ({res_valid, gt, eq, lt, busy, done} !== 6'b101001) begin
      n_fail++; $display("FAIL seq_eq_done got=%b exp=101001", {res_valid, gt, eq, lt, busy, done});
    end
    n_tests++;
    if ({fail, fail_cnt, ffa, ffb} !== {1'b1, 8'd1, 6'd3, 8'h10}) begin
      n_fail++; $display("FAIL seq_stats got=%h exp=%h", {fail, fail_cnt, ffa, ffb}, {1'b1, 8'd1, 6'd3, 8'h10});
    end
  endtask

  task automatic test_mask();
    do_reset();
    do_start();
    drive_cmp(8'hF0, 8'hF1, 8'hF0, 6'd7, 1'b0);
    step();
    n_tests++;
    if ({res_valid, gt, eq, lt, fail} !== 5'b10100) begin
      n_fail++; $display("FAIL mask_partial got=%b exp=10100", {res_valid, gt, eq, lt, fail});
    end
    drive_cmp(8'h12, 8'hED, 8'h00, 6'd8, 1'b0);
    step();
    n_tests++;
    if ({res_valid, eq, fail, fail_cnt} !== {3'b110, 8'd0}) begin
      n_fail++; $display("FAIL mask_zero got=%h exp=%h", {res_valid, eq, fail, fail_cnt}, {3'b110, 8'd0});
    end
    drive_cmp(8'hF0, 8'hF1, 8'hFF, 6'd9, 1'b0);
    step();
    idle_inputs();
    n_tests++;
    if ({res_valid, gt, eq, lt, fail, ffb, ffa} !== {5'b10011, 8'h01, 6'd9}) begin
      n_fail++; $display("FAIL mask_full got=%h exp=%h", {res_valid, gt, eq, lt, fail, ffb, ffa}, {5'b10011, 8'h01, 6'd9});
    end
  endtask

  task automatic test_back_to_back_saturation();
    logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    do_start();
    for (int i = 0; i < 5; i++) begin
      drive_cmp(8'h01, 8'h80, 8'hFF, 6'(10 + i), 1'b0);
      start = (i == 2);  // start must be ignored while RUN
      step();
      n_tests++;
      if ({res_valid2, lt2, fail_cnt2, ffa2} !== {2'b11, exp2[i], 6'd10}) begin
        n_fail++; $display("FAIL sat_cw2[%0d] got=%h exp=%h", i, {res_valid2, lt2, fail_cnt2, ffa2}, {2'b11, exp2[i], 6'd10});
      end
      n_tests++;
      if ({res_valid, fail_cnt, ffa, ffb} !== {1'b1, 8'(i + 1), 6'd10, 8'h81}) begin
        n_fail++; $display("FAIL b2b_cw8[%0d] got=%h exp=%h", i, {res_valid, fail_cnt, ffa, ffb}, {1'b1, 8'(i + 1), 6'd10, 8'h81});
      end
    end
    idle_inputs();
  endtask

  task automatic test_ignore_outside_run();
    do_reset();
    drive_cmp(8'hFF, 8'h00, 8'hFF, 6'd1, 1'b1);
    step();
    idle_inputs();
    step();
    n_tests++;
    if ({res_valid, fail, fail_cnt, busy, done} !== 12'h0) begin
      n_fail++; $display("FAIL ign_idle got=%h exp=000", {res_valid, fail, fail_cnt, busy, done});
    end
    do_start();
    drive_cmp(8'h01, 8'h02, 8'hFF, 6'd2, 1'b1);
    step();
    idle_inputs();
    drive_cmp(8'hFF, 8'h00, 8'hFF, 6'd6, 1'b0);
    step();
    idle_inputs();
    step();
    n_tests++;
    if ({res_valid, done, fail, fail_cnt, ffa, ffb} !== {3'b011, 8'd1, 6'd2, 8'h03}) begin
      n_fail++; $display("FAIL ign_done got=%h exp=%h", {res_valid, done, fail, fail_cnt, ffa, ffb}, {3'b011, 8'd1, 6'd2, 8'h03});
    end
    start = 1'b1;
    drive_cmp(8'hFF, 8'h00, 8'hFF, 6'd6, 1'b0);
    step();
    idle_inputs();
    n_tests++;
    if ({res_valid, busy, done, fail, fail_cnt, ffa} !== {4'b0100, 8'd0, 6'd0}) begin
      n_fail++; $display("FAIL restart_clear got=%h exp=%h", {res_valid, busy, done, fail, fail_cnt, ffa}, {4'b0100, 8'd0, 6'd0});
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    do_start();
    drive_cmp(8'h40, 8'h00, 8'hFF, 6'd11, 1'b0);
    step();
    drive_cmp(8'h00, 8'h40, 8'hFF, 6'd12, 1'b0);
    rst = 1'b1;
    step();
    n_tests++;
    if ({res_valid, gt, eq, lt, fail, busy, done, fail_cnt, ffa, ffb} !== 29'h0) begin
      n_fail++; $display("FAIL rst_mid_run got=%h exp=0", {res_valid, gt, eq, lt, fail, busy, done, fail_cnt, ffa, ffb});
    end
    rst = 1'b0;
    step();
    idle_inputs();
    n_tests++;
    if ({res_valid, busy, fail_cnt} !== 10'h0) begin
      n_fail++; $display("FAIL rst_after got=%h exp=0", {res_valid, busy, fail_cnt});
    end
  endtask

  initial begin
    step();
    test_reset();
    test_first_fail();
    test_lt_eq_done();
    test_mask();
    test_back_to_back_saturation();
    test_ignore_outside_run();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bist_response_analyzer.md
BIST_RESPONSE_ANALYZER -- requirements
Module: bist_response_analyzer

Interface
REQ-001 Parameter DW, default 8, width of compared RAM word.
REQ-002 Parameter AW, default 6, width of RAM address tag.
REQ-003 Parameter CW, default 8, width of fail counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  begin new analysis session; clears statistics.
REQ-007 cmp_valid  in  1  data_t/ramout/addr/mask/last valid this cycle.
REQ-008 data_t  in  DW  expected (golden) data.
REQ-009 ramout  in  DW  data read from RAM under test.
REQ-010 addr  in  AW  address of the word being compared.
REQ-011 mask  in  DW  per-bit compare enable; 1 = bit compared.
REQ-012 last  in  1  marks final compare of session; qualified by cmp_valid.
REQ-013 res_valid  out  1  gt/eq/lt valid this cycle.
REQ-014 gt / eq / lt  out  1 each  masked data_t >, ==, < masked ramout (unsigned).
REQ-015 fail  out  1  sticky: any mismatch since session start.
REQ-016 fail_cnt  out  CW  number of mismatching compares, saturating.
REQ-017 first_fail_addr  out  AW  addr of first mismatch in session.
REQ-018 first_fail_bits  out  DW  (data_t ^ ramout) & mask of first mismatch.
REQ-019 busy  out  1  high in RUN; done  out  1  high in DONE.

Function
REQ-020 FSM states IDLE, RUN, DONE.
REQ-021 IDLE -> RUN on start; DONE -> RUN on start; RUN ignores start.
REQ-022 RUN -> DONE on cmp_valid && last, after that compare is accounted.
REQ-023 Entry into RUN clears fail, fail_cnt, first_fail_addr, first_fail_bits in the same edge.
REQ-024 cmp_valid outside RUN is ignored: no res_valid, no statistic change.
REQ-025 Compare uses a = data_t & mask, b = ramout & mask; exactly one of gt/eq/lt high when res_valid.
REQ-026 Latency 1: compare accepted at edge N drives res_valid and gt/eq/lt after edge N; res_valid high for one cycle per accepted compare; back-to-back compares every cycle are supported.
REQ-027 gt/eq/lt hold last value when res_valid low.
REQ-028 Mismatch = !eq; on mismatch fail set, fail_cnt += 1 unless already 2^CW-1 (saturates, no wrap).
REQ-029 first_fail_addr/bits load only on first mismatch of session (fail was 0); later mismatches leave them.
REQ-030 mask = 0 gives eq = 1 regardless of data (never a mismatch).
REQ-031 Statistics hold stable in DONE until next start.
REQ-032 start and cmp_valid in the same IDLE/DONE cycle: start taken, compare dropped.

Reset
REQ-033 rst high at an edge: state IDLE; res_valid, gt, lt, fail, busy, done = 0; eq = 0; fail_cnt, first_fail_addr, first_fail_bits = 0.
REQ-034 rst overrides start and cmp_valid in the same cycle; reset mid-RUN abandons the session with no further res_valid.

Structure
REQ-035 Shared package bist_pkg holds the FSM state enum typedef and default-parameter constants.
REQ-036 One combinational sub-module, bist_mask_compare (parameter DW), producing gt/eq/lt and mismatch bits; the top holds the FSM, registers and counter.

Verification
REQ-037 Reset, then start, compare data_t=8'h10, ramout=8'h00, mask=8'hFF, addr=5 -> next cycle res_valid=1, gt=1; fail=1, fail_cnt=1, first_fail_addr=5, first_fail_bits=8'h10.
REQ-038 Compare data_t=8'h20, ramout=8'h30, mask=8'hFF, addr=3, then 8'h50 vs 8'h50 with last -> lt=1 then eq=1; DONE, busy=0, done=1, fail_cnt=1, first_fail_addr=3.
REQ-039 data_t=8'hF0, ramout=8'hF1, mask=8'hF0 -> eq=1, fail=0; mask=8'hFF -> lt=1, fail=1, first_fail_bits=8'h01.
REQ-040 CW=2: five consecutive mismatching compares -> fail_cnt sequence 1,2,3,3,3; first_fail_addr from first compare only.
REQ-041 cmp_valid pulses in IDLE and DONE -> no res_valid, statistics unchanged; start from DONE -> fail=0, fail_cnt=0 next cycle.
REQ-042 rst asserted mid-RUN with cmp_valid=1 -> next cycle IDLE, all outputs per REQ-033, no res_valid.
